// File: rtl/expstate_irq_bridge.sv
// Turns a producer core's exported TIE state into masked, per-channel interrupt lines
// for a consumer core, with level/edge/both-edge triggering and a small register port.
module expstate_irq_bridge #(
    parameter int NUM_IRQ   = 32,
    parameter int EXP_WIDTH = 32,
    parameter int SRC_BASE  = 0
) (
    input  logic                 CLK,
    input  logic                 BReset_n,
    input  logic [EXP_WIDTH-1:0] TIE_EXPSTATE,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [2:0]           req_addr,
    input  logic [31:0]          req_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [31:0]          rsp_rdata,
    output logic [NUM_IRQ-1:0]   BInterruptXX
);

    typedef enum logic [2:0] {
        REG_STATE = 3'd0,
        REG_PEND  = 3'd1,
        REG_MASK  = 3'd2,
        REG_EDGE  = 3'd3,
        REG_POL   = 3'd4,
        REG_BOTH  = 3'd5,
        REG_CTRL  = 3'd6,
        REG_IRQ   = 3'd7
    } reg_addr_e;

    if (SRC_BASE + NUM_IRQ > EXP_WIDTH) begin : g_bad_range
        $error("expstate_irq_bridge: SRC_BASE+NUM_IRQ exceeds EXP_WIDTH");
    end

    logic [NUM_IRQ-1:0] prev_q, mask_q, edge_q, pol_q, both_q, sticky_q, irq_q;
    logic [NUM_IRQ-1:0] mask_d, edge_d, pol_d, both_d, sticky_d;
    logic               primed_q, gen_q, gen_d, rsp_valid_q;
    logic [31:0]        rsp_rdata_q;

    logic [NUM_IRQ-1:0] in_w, wdata_w, event_w, pend_w, clr_w;
    logic [31:0]        rdata_w;
    logic               wr_acc, rd_acc;
    reg_addr_e          addr_w;

    assign in_w    = TIE_EXPSTATE[SRC_BASE +: NUM_IRQ];
    assign wdata_w = req_wdata[NUM_IRQ-1:0];
    assign addr_w  = reg_addr_e'(req_addr);

    assign req_ready = ~rsp_valid_q | rsp_ready;
    assign wr_acc    = req_valid & req_ready & req_write;
    assign rd_acc    = req_valid & req_ready & ~req_write;

    // Edge detection is suppressed until one real sample has landed in prev_q.
    assign event_w = edge_q & {NUM_IRQ{primed_q}} &
                     ((both_q & (in_w ^ prev_q)) |
                      (~both_q &  pol_q & in_w & ~prev_q) |
                      (~both_q & ~pol_q & ~in_w & prev_q));

    assign pend_w = (edge_q & sticky_q) | (~edge_q & ~(in_w ^ pol_q));

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        mask_d  = mask_q;
        edge_d  = edge_q;
        pol_d   = pol_q;
        both_d  = both_q;
        gen_d   = gen_q;
        clr_w   = '0;
        rdata_w = 32'd0;
        if (wr_acc) begin
            case (addr_w)
                REG_PEND: clr_w  = wdata_w;
                REG_MASK: mask_d = wdata_w;
                REG_EDGE: edge_d = wdata_w;
                REG_POL:  pol_d  = wdata_w;
                REG_BOTH: both_d = wdata_w;
                REG_CTRL: begin
                    gen_d = req_wdata[0];
                    if (req_wdata[1]) clr_w = '1;
                end
                default: ;
            endcase
        end
        case (addr_w)
            REG_STATE: rdata_w = 32'(in_w);
            REG_PEND:  rdata_w = 32'(pend_w);
            REG_MASK:  rdata_w = 32'(mask_q);
            REG_EDGE:  rdata_w = 32'(edge_q);
            REG_POL:   rdata_w = 32'(pol_q);
            REG_BOTH:  rdata_w = 32'(both_q);
            REG_CTRL:  rdata_w = {31'd0, gen_q};
            REG_IRQ:   rdata_w = 32'(irq_q);
            default:   rdata_w = 32'd0;
        endcase
    end

    // A new event beats a same-cycle clear; channels leaving edge mode drop their sticky bit.
    assign sticky_d = edge_d & ((sticky_q & ~clr_w) | event_w);

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge BReset_n) begin
        if (!BReset_n) begin
            prev_q      <= '0;
            mask_q      <= '0;
            edge_q      <= '0;
            pol_q       <= '0;
            both_q      <= '0;
            sticky_q    <= '0;
            irq_q       <= '0;
            primed_q    <= 1'b0;
            gen_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
        end else begin
            prev_q   <= in_w;
            primed_q <= 1'b1;
            mask_q   <= mask_d;
            edge_q   <= edge_d;
            pol_q    <= pol_d;
            both_q   <= both_d;
            gen_q    <= gen_d;
            sticky_q <= sticky_d;
            irq_q    <= gen_q ? (pend_w & mask_q) : '0;
            if (rd_acc) begin
                rsp_valid_q <= 1'b1;
                rsp_rdata_q <= rdata_w;
            end else if (rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign rsp_valid    = rsp_valid_q;
    assign rsp_rdata    = rsp_rdata_q;
    assign BInterruptXX = irq_q;

endmodule

// File: tb/tb_expstate_irq_bridge.sv
// Bench for expstate_irq_bridge: register table, scoreboarded reads and hand-built
// interrupt timing sequences.
module tb_expstate_irq_bridge;

    localparam logic [2:0] A_STATE = 3'd0, A_PEND = 3'd1, A_MASK = 3'd2, A_EDGE = 3'd3,
                           A_POL = 3'd4, A_BOTH = 3'd5, A_CTRL = 3'd6, A_IRQ = 3'd7;

    typedef struct {
        logic        wr;
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] tie;
    logic        req_valid, req_ready, req_write;
    logic [2:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic [31:0] irq;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];
    vec_t        tbl[$];

    always #5 clk = ~clk;

    expstate_irq_bridge #(.NUM_IRQ(32), .EXP_WIDTH(32), .SRC_BASE(0)) dut (
        .CLK(clk), .BReset_n(rst_n), .TIE_EXPSTATE(tie),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .BInterruptXX(irq)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic wr, input logic [2:0] a, input logic [31:0] d,
                          input logic [31:0] exp);
        int n;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL req_timeout: req_ready got 0, expected 1");
        end else if (!wr) begin
            exp_q.push_back(exp);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        do_req(1'b1, a, d, 32'd0);
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] exp);
        do_req(1'b0, a, 32'd0, exp);
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
        check("drain_outstanding", 32'(exp_q.size()), 32'd0);
    endtask

    // Scoreboard: a response is consumed on the edge following a negedge where valid&ready.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rsp_unexpected: got 0x%08h, expected no response", rsp_rdata);
            end else begin
                check("rsp_rdata", rsp_rdata, exp_q.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tie = 32'hFFFF_FFFF;
        req_valid = 1'b0; req_write = 1'b0; req_addr = 3'd0; req_wdata = 32'd0;
        rsp_ready = 1'b1;

        // Reset state
        tick(2);
        check("rst_irq", irq, 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        rst_n = 1'b1;
        tick(2);
        check("post_rst_irq", irq, 32'd0);
        rd(A_PEND, 32'h0000_0000);
        rd(A_STATE, 32'hFFFF_FFFF);
        drain();

        // Register table
        tie = 32'h1234_5678;
        tbl.push_back('{1'b1, A_MASK,  32'hDEAD_BEEF, 32'd0});
        tbl.push_back('{1'b0, A_MASK,  32'd0,         32'hDEAD_BEEF});
        tbl.push_back('{1'b1, A_EDGE,  32'h0F0F_0000, 32'd0});
        tbl.push_back('{1'b0, A_EDGE,  32'd0,         32'h0F0F_0000});
        tbl.push_back('{1'b1, A_POL,   32'h00FF_00FF, 32'd0});
        tbl.push_back('{1'b0, A_POL,   32'd0,         32'h00FF_00FF});
        tbl.push_back('{1'b1, A_BOTH,  32'h0000_003C, 32'd0});
        tbl.push_back('{1'b0, A_BOTH,  32'd0,         32'h0000_003C});
        tbl.push_back('{1'b1, A_CTRL,  32'h0000_0003, 32'd0});
        tbl.push_back('{1'b0, A_CTRL,  32'd0,         32'h0000_0001});
        tbl.push_back('{1'b1, A_STATE, 32'hFFFF_FFFF, 32'd0});
        tbl.push_back('{1'b0, A_STATE, 32'd0,         32'h1234_5678});
        tbl.push_back('{1'b1, A_IRQ,   32'hFFFF_FFFF, 32'd0});
        tbl.push_back('{1'b1, A_CTRL,  32'h0000_0000, 32'd0});
        tbl.push_back('{1'b1, A_MASK,  32'h0000_0000, 32'd0});
        tbl.push_back('{1'b1, A_EDGE,  32'h0000_0000, 32'd0});
        tbl.push_back('{1'b1, A_POL,   32'h0000_0000, 32'd0});
        tbl.push_back('{1'b1, A_BOTH,  32'h0000_0000, 32'd0});
        tbl.push_back('{1'b0, A_IRQ,   32'd0,         32'h0000_0000});
        tbl.push_back('{1'b0, A_PEND,  32'd0,         32'hEDCB_A987});
        tbl.push_back('{1'b1, A_POL,   32'hFFFF_FFFF, 32'd0});
        tbl.push_back('{1'b0, A_PEND,  32'd0,         32'h1234_5678});
        tbl.push_back('{1'b1, A_POL,   32'h0000_0000, 32'd0});
        tbl.push_back('{1'b0, A_POL,   32'd0,         32'h0000_0000});
        for (int i = 0; i < tbl.size(); i++)
            do_req(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].exp);
        drain();

        // Rising edge on channel 3: sticky pending, then W1C
        tie = 32'd0;
        wr(A_EDGE, 32'h8); wr(A_POL, 32'hFFFF_FFFF); wr(A_MASK, 32'h8); wr(A_CTRL, 32'h1);
        tick(2);
        check("edge_idle_irq", irq, 32'd0);
        tie[3] = 1'b1;
        tick();
        check("edge_irq_t1", irq, 32'd0);
        tick();
        check("edge_irq_t2", irq, 32'h8);
        tie[3] = 1'b0;
        tick(3);
        check("edge_irq_sticky", irq, 32'h8);
        rd(A_PEND, 32'h8);
        wr(A_PEND, 32'h8);
        check("edge_irq_w1c_t1", irq, 32'h8);
        tick();
        check("edge_irq_w1c_t2", irq, 32'd0);
        drain();

        // Level channel 0, active-low
        wr(A_EDGE, 32'h0); wr(A_POL, 32'h0); wr(A_MASK, 32'h1);
        tick(2);
        check("level_low_irq", irq, 32'h1);
        tie[0] = 1'b1;
        tick();
        check("level_high_irq", irq, 32'h0);
        tie[0] = 1'b0;
        tick(2);
        check("level_low_again_irq", irq, 32'h1);
        wr(A_PEND, 32'h1);
        tick();
        check("level_w1c_ignored_irq", irq, 32'h1);
        rd(A_PEND, 32'hFFFF_FFFF);
        drain();

        // Both-edge channel 0: event coinciding with W1C keeps pending set
        wr(A_POL, 32'hFFFF_FFFE); wr(A_BOTH, 32'h1); wr(A_EDGE, 32'h1);
        tick(2);
        rd(A_PEND, 32'h0);
        drain();
        req_valid = 1'b1; req_write = 1'b1; req_addr = A_PEND; req_wdata = 32'h1;
        tie[0] = 1'b1;
        tick();
        req_valid = 1'b0;
        rd(A_PEND, 32'h1);
        tick(2);
        check("collision_irq", irq, 32'h1);
        wr(A_PEND, 32'h1);
        tick();
        rd(A_PEND, 32'h0);
        tie[0] = 1'b0;
        tick();
        rd(A_PEND, 32'h1);
        drain();

        // Response backpressure
        wr(A_EDGE, 32'h0); wr(A_BOTH, 32'h0); wr(A_MASK, 32'hA5);
        tie = 32'hCAFE_0001;
        drain();
        rsp_ready = 1'b0;
        rd(A_STATE, 32'hCAFE_0001);
        req_valid = 1'b1; req_write = 1'b0; req_addr = A_MASK;
        tie = 32'd0;
        for (int i = 0; i < 3; i++) begin
            check("bp_req_ready", 32'(req_ready), 32'd0);
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rsp_rdata_stable", rsp_rdata, 32'hCAFE_0001);
            tick();
        end
        exp_q.push_back(32'h0000_00A5);
        rsp_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        rd(A_MASK, 32'hA5);
        rd(A_STATE, 32'h0);
        rd(A_CTRL, 32'h1);
        drain();

        // Global enable gating and CLRALL
        wr(A_MASK, 32'h0); wr(A_CTRL, 32'h0); wr(A_POL, 32'hFFFF_FFFF);
        wr(A_EDGE, 32'hFF); wr(A_MASK, 32'hFF);
        tie = 32'd0;
        tick(2);
        tie = 32'hFF;
        tick(3);
        check("gen0_irq", irq, 32'd0);
        rd(A_PEND, 32'hFF);
        wr(A_CTRL, 32'h1);
        check("gen1_irq_t1", irq, 32'd0);
        tick();
        check("gen1_irq_t2", irq, 32'hFF);
        rd(A_IRQ, 32'hFF);
        wr(A_CTRL, 32'h3);
        check("clrall_irq_t1", irq, 32'hFF);
        tick();
        check("clrall_irq_t2", irq, 32'd0);
        rd(A_PEND, 32'h0);
        rd(A_CTRL, 32'h1);
        drain();

        // Reset while a read response is waiting
        wr(A_EDGE, 32'h0); wr(A_POL, 32'h0); wr(A_MASK, 32'h1);
        tie = 32'd0;
        tick(2);
        check("prerst_irq", irq, 32'h1);
        rsp_ready = 1'b0;
        rd(A_CTRL, 32'h1);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst_rsp_rdata", rsp_rdata, 32'd0);
        check("midrst_irq", irq, 32'd0);
        check("midrst_req_ready", 32'(req_ready), 32'd1);
        exp_q.delete();
        tie = 32'hFFFF_FFFF;
        rsp_ready = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(3);
        check("postrst_irq", irq, 32'd0);
        rd(A_PEND, 32'h0);
        rd(A_MASK, 32'h0);
        rd(A_STATE, 32'hFFFF_FFFF);
        rd(A_CTRL, 32'h0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
